rgb_fade_sequencer: RTL and testbench
=====================================

Name: rgb_fade_sequencer

Overview:
- Parametrised multi-channel light-mode sequencer for the breadboard RGB controller path.
- Holds a registered intensity per channel. Supports single-step brightness, preset load, tick-paced fade-in/fade-out ramps, and tick-paced blinking.
- All channel levels are real state (not combinational). Channel count, data width and step size are generics.
- Sits between the command decoder (cmd/cmd_valid) and the PWM generators (level_out).

Parameters:
- CH, 3, number of colour channels.
- W, 8, bits per channel level.
- STEP, 1, increment/decrement per step or tick. Legal range 1..2^W-1.
- BLINK_DIV, 4, ticks per blink half-period. Must be ≥1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- on  input  1  master enable. Level-sensitive; 0 forces OFF.
- cmd  input  4  command code, sampled when cmd_valid=1.
- cmd_valid  input  1  command strobe, single-cycle.
- tick  input  1  rate-enable pulse that paces fades and blink.
- preset  input  CH*W  per-channel load values. Channel c occupies bits [c*W +: W].
- level_out  output  CH*W  per-channel intensity to the PWM stage.
- state_out  output  3  OFF=0, ON=1, FADE_IN=2, FADE_OUT=3, BLINK=4.
- busy  output  1  1 in FADE_IN, FADE_OUT and BLINK.

Behaviour:

Reset:
- state=OFF, all levels=0, blink counter=0, phase=1.
- level_out=0, state_out=0, busy=0.

Commands (only acted on when cmd_valid=1; unlisted codes are ignored):
- 0x1 STEP_UP
- 0x2 STEP_DOWN
- 0x3 LOAD
- 0x4 FADE_IN
- 0x5 FADE_OUT
- 0x6 BLINK
- 0x7 ABORT

Priority:
- on=0 beats everything. From any state, the next state is OFF and all levels clear to 0 on the same edge.

OFF:
- level_out=0. Commands are ignored.
- on=1 → ON on the next edge. Levels stay 0.

ON:
- STEP_UP: every level += STEP, saturating at 2^W-1.
- STEP_DOWN: every level -= STEP, saturating at 0.
- LOAD: level[c] <= preset[c].
- FADE_IN / FADE_OUT / BLINK: transition to that state on the next edge.
- ABORT: no-op.
- level_out = levels.

FADE_IN:
- On each tick, every level += STEP (saturating).
- Leaves to ON on the edge after all channels equal 2^W-1. If it is entered already at max, it returns to ON one cycle later.

FADE_OUT:
- Symmetric to FADE_IN, toward 0.

BLINK:
- On entry: counter=0, phase=1.
- On each tick: if counter==BLINK_DIV-1, then counter=0 and phase toggles; otherwise counter+1.
- level_out = phase ? levels : 0. Levels are not modified.

Busy states (FADE_IN, FADE_OUT, BLINK):
- Only ABORT is honoured; all other commands are dropped.
- ABORT → ON next edge with levels held at their current values.
- If ABORT and tick arrive in the same cycle, ABORT wins and no step is applied.

Arithmetic:
- Saturation is computed per channel in W+1 bits.
- Channels are independent. In FADE, a channel already at its limit stays there while the others continue stepping.

Latency:
- A command sampled at edge n is visible on level_out/state_out after edge n.
- All outputs are pure functions of registers; there is no combinational path from inputs.

Reset mid-operation:
- Any state, including mid-fade or mid-blink, returns immediately to the reset values above.

Test Plan:
1. Parameters CH=3, W=8, STEP=16. Reset, on=1, then LOAD with preset {B,G,R}={0x10,0x80,0xF8}. Required: state_out 0→1, level_out=0x1080F8 the cycle after LOAD.
2. From test 1, issue 3×STEP_UP. Required: R saturates at 0xFF, G=0xB0, B=0x40. Then 5×STEP_DOWN. Required: B=0x00 (saturated), G=0x60, R=0xAF.
3. From all zero, FADE_IN with one tick every 4 clocks. Required:
   - levels follow 0x10, 0x20, …, 0xF0, then 0xFF on the 16th tick;
   - busy=1 throughout;
   - state_out returns to 1 one cycle after all channels reach 0xFF.
4. Levels=0x404040, BLINK_DIV=2, BLINK, then continuous ticks. Required:
   - level_out = 0x404040 for 2 ticks, then 0 for 2 ticks, repeating;
   - ABORT issued during the off phase → state ON, level_out=0x404040 on the next cycle.
5. Mid FADE_OUT at level 0x70: assert ABORT and tick in the same cycle. Required: level stays 0x70 and state=ON. A STEP_UP sent during FADE_OUT (before the abort) is ignored.
6. Mid BLINK: drop on=0. Required: state_out=0 and level_out=0 after one edge, with levels cleared. Separately, assert reset mid FADE_IN. Required: all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rgb_fade_sequencer.sv
// Multi-channel light-mode sequencer: step, preset load, tick-paced fade ramps and blink.
// Channel levels are registered; outputs are registered from next-state values.
module rgb_fade_sequencer #(
    parameter int unsigned CH        = 3,
    parameter int unsigned W         = 8,
    parameter int unsigned STEP      = 1,
    parameter int unsigned BLINK_DIV = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            on,
    input  logic [3:0]      cmd,
    input  logic            cmd_valid,
    input  logic            tick,
    input  logic [CH*W-1:0] preset,
    output logic [CH*W-1:0] level_out,
    output logic [2:0]      state_out,
    output logic            busy
);

    localparam int unsigned CntW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(BLINK_DIV - 1);
    localparam logic [W-1:0] MaxLvl = {W{1'b1}};
    localparam logic [W:0]   MaxW   = {1'b0, {W{1'b1}}};
    localparam logic [W:0]   StepW  = (W+1)'(STEP);

    localparam logic [3:0] CmdStepUp   = 4'h1;
    localparam logic [3:0] CmdStepDown = 4'h2;
    localparam logic [3:0] CmdLoad     = 4'h3;
    localparam logic [3:0] CmdFadeIn   = 4'h4;
    localparam logic [3:0] CmdFadeOut  = 4'h5;
    localparam logic [3:0] CmdBlink    = 4'h6;
    localparam logic [3:0] CmdAbort    = 4'h7;

    typedef enum logic [2:0] {
        StOff     = 3'd0,
        StOn      = 3'd1,
        StFadeIn  = 3'd2,
        StFadeOut = 3'd3,
        StBlink   = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [CH-1:0][W-1:0]   level_q, level_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   phase_q, phase_d;
    logic [CH*W-1:0]        out_q, out_d;
    logic                   busy_q, busy_d;

    logic                   abort;
    logic                   all_max;
    logic                   all_zero;
    logic [CH-1:0][W-1:0]   level_up;
    logic [CH-1:0][W-1:0]   level_dn;

    // Saturation is evaluated in W+1 bits so the carry/borrow is visible.
    function automatic logic [W-1:0] sat_up(input logic [W-1:0] l);
        logic [W:0] sum;
        sum = {1'b0, l} + StepW;
        return (sum > MaxW) ? MaxLvl : sum[W-1:0];
    endfunction

    function automatic logic [W-1:0] sat_dn(input logic [W-1:0] l);
        logic [W:0] diff;
        diff = {1'b0, l} - StepW;
        return diff[W] ? '0 : diff[W-1:0];
    endfunction

    always_comb begin
        abort    = cmd_valid && (cmd == CmdAbort);
        all_max  = 1'b1;
        all_zero = 1'b1;
        level_up = '0;
        level_dn = '0;
        for (int c = 0; c < CH; c++) begin
            level_up[c] = sat_up(level_q[c]);
            level_dn[c] = sat_dn(level_q[c]);
            if (level_q[c] != MaxLvl) all_max = 1'b0;
            if (level_q[c] != '0)     all_zero = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (!on) begin
            state_d = StOff;
            level_d = '0;
            cnt_d   = '0;
            phase_d = 1'b1;
        end else begin
            unique case (state_q)
                StOff: state_d = StOn;
                StOn: begin
                    if (cmd_valid) begin
                        case (cmd)
                            CmdStepUp:   level_d = level_up;
                            CmdStepDown: level_d = level_dn;
                            CmdLoad:     level_d = preset;
                            CmdFadeIn:   state_d = StFadeIn;
                            CmdFadeOut:  state_d = StFadeOut;
                            CmdBlink: begin
                                state_d = StBlink;
                                cnt_d   = '0;
                                phase_d = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                StFadeIn: begin
                    if (abort || all_max) state_d = StOn;
                    else if (tick)        level_d = level_up;
                end
                StFadeOut: begin
                    if (abort || all_zero) state_d = StOn;
                    else if (tick)         level_d = level_dn;
                end
                StBlink: begin
                    if (abort) begin
                        state_d = StOn;
                    end else if (tick) begin
                        if (cnt_q == CntLast) begin
                            cnt_d   = '0;
                            phase_d = ~phase_q;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end
                end
                default: state_d = StOff;
            endcase
        end
        // Outputs are registered from next-state so a command is visible right after its edge.
        out_d  = (state_d == StBlink && !phase_d) ? '0 : level_d;
        busy_d = (state_d == StFadeIn) || (state_d == StFadeOut) || (state_d == StBlink);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StOff;
            level_q <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b1;
            out_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
        end
    end

    assign level_out = out_q;
    assign state_out = state_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Bench for rgb_fade_sequencer: directed scenarios plus random traffic checked
// against an integer reference model of the light modes.
module tb_rgb_fade_sequencer;

    localparam int CH   = 3;
    localparam int W    = 8;
    localparam int STEP = 16;
    localparam int BDIV = 2;
    localparam int MAXV = 255;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        on = 1'b0;
    logic [3:0]  cmd = 4'h0;
    logic        cmd_valid = 1'b0;
    logic        tick = 1'b0;
    logic [23:0] preset = 24'h0;
    logic [23:0] level_out;
    logic [2:0]  state_out;
    logic        busy;

    int tests = 0;
    int fails = 0;

    // Reference model: mode 0..4 as in state_out, plain integer levels.
    int m_lv[3];
    int m_st;
    int m_cnt;
    bit m_ph;

    always #5 clk = ~clk;

    rgb_fade_sequencer #(
        .CH(CH),
        .W(W),
        .STEP(STEP),
        .BLINK_DIV(BDIV)
    ) dut (
        .clk(clk),
        .reset(reset),
        .on(on),
        .cmd(cmd),
        .cmd_valid(cmd_valid),
        .tick(tick),
        .preset(preset),
        .level_out(level_out),
        .state_out(state_out),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] m_level();
        logic [23:0] v;
        v = '0;
        if (m_st == 4 && !m_ph) return v;
        for (int c = 0; c < 3; c++) v[c*8 +: 8] = 8'(m_lv[c]);
        return v;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) m_lv[c] = 0;
        m_st  = 0;
        m_cnt = 0;
        m_ph  = 1'b1;
    endtask

    task automatic model_apply(input bit s_on, input bit s_valid, input bit s_tick,
                               input logic [3:0] s_cmd, input logic [23:0] s_pre);
        bit ab;
        bit amax;
        bit azero;
        ab    = s_valid && (s_cmd == 4'h7);
        amax  = (m_lv[0] == MAXV) && (m_lv[1] == MAXV) && (m_lv[2] == MAXV);
        azero = (m_lv[0] == 0) && (m_lv[1] == 0) && (m_lv[2] == 0);
        if (!s_on) begin
            model_reset();
            return;
        end
        case (m_st)
            0: m_st = 1;
            1: if (s_valid) begin
                case (s_cmd)
                    4'h1: for (int c = 0; c < 3; c++)
                        m_lv[c] = (m_lv[c] + STEP > MAXV) ? MAXV : m_lv[c] + STEP;
                    4'h2: for (int c = 0; c < 3; c++)
                        m_lv[c] = (m_lv[c] < STEP) ? 0 : m_lv[c] - STEP;
                    4'h3: for (int c = 0; c < 3; c++) m_lv[c] = int'(s_pre[c*8 +: 8]);
                    4'h4: m_st = 2;
                    4'h5: m_st = 3;
                    4'h6: begin m_st = 4; m_cnt = 0; m_ph = 1'b1; end
                    default: ;
                endcase
            end
            2: begin
                if (ab || amax) m_st = 1;
                else if (s_tick) for (int c = 0; c < 3; c++)
                    m_lv[c] = (m_lv[c] + STEP > MAXV) ? MAXV : m_lv[c] + STEP;
            end
            3: begin
                if (ab || azero) m_st = 1;
                else if (s_tick) for (int c = 0; c < 3; c++)
                    m_lv[c] = (m_lv[c] < STEP) ? 0 : m_lv[c] - STEP;
            end
            default: begin
                if (ab) m_st = 1;
                else if (s_tick) begin
                    m_cnt++;
                    if (m_cnt == BDIV) begin m_cnt = 0; m_ph = !m_ph; end
                end
            end
        endcase
    endtask

    task automatic check_model(input string tag);
        check({tag, "/level"}, {8'h0, level_out}, {8'h0, m_level()});
        check({tag, "/state"}, {29'h0, state_out}, 32'(m_st));
        check({tag, "/busy"}, {31'h0, busy}, {31'h0, (m_st >= 2)});
    endtask

    task automatic step(input string tag);
        bit s_on, s_valid, s_tick;
        logic [3:0] s_cmd;
        logic [23:0] s_pre;
        s_on = on; s_valid = cmd_valid; s_tick = tick; s_cmd = cmd; s_pre = preset;
        @(posedge clk);
        #1;
        model_apply(s_on, s_valid, s_tick, s_cmd, s_pre);
        check_model(tag);
    endtask

    task automatic send(input logic [3:0] c, input string tag);
        cmd_valid = 1'b1;
        cmd = c;
        step(tag);
        cmd_valid = 1'b0;
        cmd = 4'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_model("reset_async");
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_model("reset_hold");
    endtask

    initial begin
        bit ph_tbl[6];
        ph_tbl = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        model_reset();
        do_reset();
        check("t0_level", {8'h0, level_out}, 32'h0);

        // 1: power up and load preset
        on = 1'b1;
        step("t1_on");
        check("t1_state_on", {29'h0, state_out}, 32'h1);
        preset = 24'h1080F8;
        send(4'h3, "t1_load");
        check("t1_loaded", {8'h0, level_out}, 32'h1080F8);

        // 2: saturating steps
        for (int i = 0; i < 3; i++) send(4'h1, "t2_up");
        check("t2_after_up", {8'h0, level_out}, 32'h40B0FF);
        for (int i = 0; i < 5; i++) send(4'h2, "t2_dn");
        check("t2_after_dn", {8'h0, level_out}, 32'h0060AF);

        // 3: fade-in from zero, one tick every four clocks
        preset = 24'h0;
        send(4'h3, "t3_zero");
        send(4'h4, "t3_fadein");
        for (int k = 1; k <= 16; k++) begin
            for (int j = 0; j < 3; j++) step("t3_idle");
            tick = 1'b1;
            step("t3_tick");
            tick = 1'b0;
            check("t3_ramp", {8'h0, level_out}, (k < 16) ? {8'h0, {3{8'(k*16)}}} : 32'hFFFFFF);
            check("t3_busy", {31'h0, busy}, 32'h1);
        end
        check("t3_still_fading", {29'h0, state_out}, 32'h2);
        step("t3_exit");
        check("t3_back_on", {29'h0, state_out}, 32'h1);
        check("t3_not_busy", {31'h0, busy}, 32'h0);

        // 4: blink with continuous ticks, abort in off phase
        preset = 24'h404040;
        send(4'h3, "t4_load");
        send(4'h6, "t4_blink");
        check("t4_entry", {8'h0, level_out}, 32'h404040);
        tick = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step("t4_tick");
            check("t4_pattern", {8'h0, level_out}, ph_tbl[k] ? 32'h404040 : 32'h0);
        end
        send(4'h7, "t4_abort");
        tick = 1'b0;
        check("t4_abort_state", {29'h0, state_out}, 32'h1);
        check("t4_abort_level", {8'h0, level_out}, 32'h404040);

        // 5: fade-out, ignored step-up, abort racing a tick
        preset = 24'h909090;
        send(4'h3, "t5_load");
        send(4'h5, "t5_fadeout");
        tick = 1'b1; step("t5_tick"); tick = 1'b0;
        send(4'h1, "t5_stepup");
        check("t5_stepup_ignored", {8'h0, level_out}, 32'h808080);
        tick = 1'b1; step("t5_tick"); tick = 1'b0;
        check("t5_at_70", {8'h0, level_out}, 32'h707070);
        tick = 1'b1;
        send(4'h7, "t5_abort_tick");
        tick = 1'b0;
        check("t5_abort_level", {8'h0, level_out}, 32'h707070);
        check("t5_abort_state", {29'h0, state_out}, 32'h1);

        // 6: on=0 mid-blink, then async reset mid-fade
        preset = 24'h505050;
        send(4'h3, "t6_load");
        send(4'h6, "t6_blink");
        tick = 1'b1;
        for (int k = 0; k < 3; k++) step("t6_tick");
        tick = 1'b0;
        on = 1'b0;
        step("t6_off");
        check("t6_off_state", {29'h0, state_out}, 32'h0);
        check("t6_off_level", {8'h0, level_out}, 32'h0);
        on = 1'b1;
        step("t6_reon");
        check("t6_cleared", {8'h0, level_out}, 32'h0);
        preset = 24'h101010;
        send(4'h3, "t6_load2");
        send(4'h4, "t6_fadein");
        tick = 1'b1; step("t6_tick2"); tick = 1'b0;
        check("t6_mid_fade", {8'h0, level_out}, 32'h202020);
        reset = 1'b1;
        #1;
        check("t6_rst_level", {8'h0, level_out}, 32'h0);
        check("t6_rst_state", {29'h0, state_out}, 32'h0);
        check("t6_rst_busy", {31'h0, busy}, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_model("t6_rst_release");

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            on        = ($urandom_range(0, 39) != 0);
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd       = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                    : 4'($urandom_range(1, 7));
            tick      = ($urandom_range(0, 2) == 0);
            preset    = 24'($urandom);
            if ($urandom_range(0, 299) == 0) do_reset();
            else step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
